// File: rtl/regfile_pkg.sv
// Shared widths and the write-back queue entry type for the register file slice.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue: DEPTH entries, FIFO order, full/empty distinguished by the count.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             pop_entry,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic [PTR_W-1:0]      head,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_entry;
  end

  assign pop_entry = mem_q[head_q];
  assign count     = count_q;
  assign head      = head_q;
  assign entries   = mem_q;

endmodule

// File: rtl/regfile_wb_buffer.sv
// Register file with a write-back queue that commits only while phase_in is high.
// Define REGFILE_BYPASS_EN to forward queued writes to the read ports.
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phase_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic [PTR_W:0]    pending,
  output logic              overflow
);

  logic             full, empty, push, commit, overflow_q;
  wb_entry_t        push_entry, pop_entry;
  logic [DATA_W-1:0] regs_q [NREG];

`ifdef REGFILE_BYPASS_EN
  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head;
`else
  wb_entry_t [DEPTH-1:0] unused_entries;
  logic [PTR_W-1:0]      unused_head;
`endif

  assign wr_ready   = !full;
  // Writes to r0 are accepted but never enqueued.
  assign push       = wr_valid && wr_ready && (wr_addr != '0);
  assign commit     = phase_in && !empty;
  assign push_entry = '{addr: wr_addr, data: wr_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (commit),
    .pop_entry (pop_entry),
    .full      (full),
    .empty     (empty),
    .count     (pending),
`ifdef REGFILE_BYPASS_EN
    .head      (head),
    .entries   (entries)
`else
    .head      (unused_head),
    .entries   (unused_entries)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[pop_entry.addr] <= pop_entry.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  // Scan oldest to newest so the newest matching queued entry wins.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < pending) && (entries[idx].addr == addr)) val = entries[idx].data;
    end
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  assign rd0_data = read_reg(rd0_addr);
  assign rd1_data = read_reg(rd1_addr);

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: directed scenarios plus random traffic
// against a queue-and-array reference model.
module tb_regfile_wb_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        phase_in = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd0_addr = '0;
  logic [4:0]  rd1_addr = '0;
  logic [31:0] rd0_data, rd1_data;
  logic [2:0]  pending;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        ref_q[$];
  logic [31:0] ref_arr[32];
  bit          ref_ovf;

  regfile_wb_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .phase_in(phase_in),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd0_addr(rd0_addr),
    .rd1_addr(rd1_addr),
    .rd0_data(rd0_data),
    .rd1_data(rd1_data),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    for (int i = ref_q.size() - 1; i >= 0; i--) begin
      if (ref_q[i].addr == a) return ref_q[i].data;
    end
`endif
    return ref_arr[a];
  endfunction

  task automatic model_clear();
    ref_q.delete();
    for (int i = 0; i < 32; i++) ref_arr[i] = 32'd0;
    ref_ovf = 1'b0;
  endtask

  // Advance the model by one edge using the inputs the DUT is about to sample.
  task automatic cycle();
    bit   acc, pop;
    ent_t e;
    acc = wr_valid && (ref_q.size() < DEPTH);
    pop = phase_in && (ref_q.size() > 0);
    if (wr_valid && ref_q.size() == DEPTH) ref_ovf = 1'b1;
    if (pop) begin
      e = ref_q.pop_front();
      ref_arr[e.addr] = e.data;
    end
    if (acc && wr_addr != 5'd0) begin
      e.addr = wr_addr;
      e.data = wr_data;
      ref_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_clear();
    #2 reset = 1'b0;
    rd0_addr = 5'd5;
    rd1_addr = 5'd0;
    #1;
    n_cmp++; if (rd0_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_r5 got %h want 0", rd0_data); end
    n_cmp++; if (rd1_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_r0 got %h want 0", rd1_data); end
    n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL reset_pending got %0d want 0", pending); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_hold_commit();
    logic [31:0] exp;
    phase_in = 1'b0;
    write(5'd3, 32'hA5A5_0001);
    rd0_addr = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5_0001;
`else
    exp = 32'd0;
`endif
    n_cmp++; if (pending !== 3'd1) begin n_err++; $display("FAIL hold_pending got %0d want 1", pending); end
    n_cmp++; if (rd0_data !== exp) begin n_err++; $display("FAIL hold_bypass got %h want %h", rd0_data, exp); end
    phase_in = 1'b1;
    cycle();
    phase_in = 1'b0;
    n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL commit_pending got %0d want 0", pending); end
    n_cmp++; if (rd0_data !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL commit_array got %h want a5a50001", rd0_data);
    end
  endtask

  task automatic test_fill_overflow();
    phase_in = 1'b0;
    for (int i = 1; i <= 4; i++) write(5'(i), 32'(i));
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready got %b want 0", wr_ready); end
    n_cmp++; if (pending !== 3'd4) begin n_err++; $display("FAIL full_pending got %0d want 4", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pre_overflow got %b want 0", overflow); end
    write(5'd6, 32'd6);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set got %b want 1", overflow); end
    n_cmp++; if (pending !== 3'd4) begin n_err++; $display("FAIL overflow_pending got %0d want 4", pending); end
    phase_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rd0_addr = 5'(k);
      rd1_addr = 5'(k + 1);
      cycle();
      n_cmp++; if (pending !== 3'(4 - k)) begin
        n_err++; $display("FAIL drain_pending_%0d got %0d want %0d", k, pending, 4 - k);
      end
      n_cmp++; if (rd0_data !== 32'(k)) begin
        n_err++; $display("FAIL drain_commit_r%0d got %h want %h", k, rd0_data, 32'(k));
      end
      n_cmp++; if (rd1_data !== ref_read(5'(k + 1))) begin
        n_err++; $display("FAIL drain_next_r%0d got %h want %h", k + 1, rd1_data, ref_read(5'(k + 1)));
      end
    end
    phase_in = 1'b0;
    rd1_addr = 5'd6;
    #1;
    n_cmp++; if (rd1_data !== 32'd0) begin n_err++; $display("FAIL dropped_r6 got %h want 0", rd1_data); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky got %b want 1", overflow); end
  endtask

  task automatic test_same_reg();
    logic [31:0] exp;
    phase_in = 1'b0;
    write(5'd7, 32'h11);
    write(5'd7, 32'h22);
    rd0_addr = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h22;
`else
    exp = 32'd0;
`endif
    n_cmp++; if (rd0_data !== exp) begin n_err++; $display("FAIL same_reg_bypass got %h want %h", rd0_data, exp); end
    phase_in = 1'b1;
    cycle();
    n_cmp++; if (rd0_data !== ref_read(5'd7)) begin
      n_err++; $display("FAIL same_reg_mid got %h want %h", rd0_data, ref_read(5'd7));
    end
    cycle();
    phase_in = 1'b0;
    n_cmp++; if (rd0_data !== 32'h22) begin n_err++; $display("FAIL same_reg_final got %h want 22", rd0_data); end
    n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL same_reg_pending got %0d want 0", pending); end
  endtask

  task automatic test_r0_discard();
    phase_in = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL r0_wr_ready got %b want 1", wr_ready); end
    write(5'd0, 32'hFFFF_FFFF);
    rd0_addr = 5'd0;
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL r0_pending got %0d want 0", pending); end
    n_cmp++; if (rd0_data !== 32'd0) begin n_err++; $display("FAIL r0_read got %h want 0", rd0_data); end
  endtask

  task automatic test_concurrency_reset();
    phase_in = 1'b0;
    write(5'd8, 32'h80);
    write(5'd9, 32'h90);
    n_cmp++; if (pending !== 3'd2) begin n_err++; $display("FAIL conc_pre_pending got %0d want 2", pending); end
    phase_in = 1'b1;
    rd0_addr = 5'd8;
    rd1_addr = 5'd10;
    write(5'd10, 32'hA0);
    phase_in = 1'b0;
    n_cmp++; if (pending !== 3'd2) begin n_err++; $display("FAIL conc_pending got %0d want 2", pending); end
    n_cmp++; if (rd0_data !== 32'h80) begin n_err++; $display("FAIL conc_commit got %h want 80", rd0_data); end
    n_cmp++; if (rd1_data !== ref_read(5'd10)) begin
      n_err++; $display("FAIL conc_push got %h want %h", rd1_data, ref_read(5'd10));
    end
    #2 reset = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_err++; $display("FAIL midrst_pending got %0d want 0", pending); end
    n_cmp++; if (rd0_data !== 32'd0) begin n_err++; $display("FAIL midrst_r8 got %h want 0", rd0_data); end
    n_cmp++; if (rd1_data !== 32'd0) begin n_err++; $display("FAIL midrst_r10 got %h want 0", rd1_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_overflow got %b want 0", overflow); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL midrst_wr_ready got %b want 1", wr_ready); end
    #2 reset = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (c < 150) phase_in = ((c % 6) >= 2);
      else         phase_in = 1'($urandom_range(0, 1));
      wr_valid = ($urandom_range(0, 9) < 7);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rd0_addr = 5'($urandom_range(0, 7));
      rd1_addr = 5'($urandom_range(0, 7));
      #1;
      n_cmp++; if (rd0_data !== ref_read(rd0_addr)) begin
        n_err++; $display("FAIL rand_rd0 c=%0d r%0d got %h want %h", c, rd0_addr, rd0_data, ref_read(rd0_addr));
      end
      n_cmp++; if (rd1_data !== ref_read(rd1_addr)) begin
        n_err++; $display("FAIL rand_rd1 c=%0d r%0d got %h want %h", c, rd1_addr, rd1_data, ref_read(rd1_addr));
      end
      n_cmp++; if (pending !== 3'(ref_q.size())) begin
        n_err++; $display("FAIL rand_pending c=%0d got %0d want %0d", c, pending, ref_q.size());
      end
      n_cmp++; if (wr_ready !== (ref_q.size() < DEPTH)) begin
        n_err++; $display("FAIL rand_wr_ready c=%0d got %b want %b", c, wr_ready, ref_q.size() < DEPTH);
      end
      n_cmp++; if (overflow !== ref_ovf) begin
        n_err++; $display("FAIL rand_overflow c=%0d got %b want %b", c, overflow, ref_ovf);
      end
      cycle();
    end
    wr_valid = 1'b0;
    phase_in = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_hold_commit();
    test_fill_overflow();
    test_same_reg();
    test_r0_discard();
    test_concurrency_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
